return_stack_spec: RTL and testbench

- Parametrised return-address stack (RAS) for the branch predictor; next generation of the single-push/single-pop return stack.
- Adds combined push+pop (replace-top), overflow wrap with oldest-entry loss, synchronous clear, and checkpoint/recover for mispredict repair.
- Front end pushes on calls and pops on returns, and takes a checkpoint per predicted branch. The backend restores a checkpoint on mispredict.

---
 rtl/return_stack_spec_if.sv | 36 +++
 rtl/return_stack_spec.sv | 102 ++++++++++
 tb/tb_return_stack_spec.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/return_stack_spec_if.sv
`default_nettype none
// ============================================================================
// Module   : return_stack_spec_if
// Brief    : Request/response bundle between the front end and the RAS.
// Revision : 1.0
// ============================================================================
interface return_stack_spec_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 31
);
    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_cnt_w  = $clog2(DEPTH) + 1;
    localparam int c_ckpt_w = c_ptr_w + c_cnt_w + WIDTH;

    logic                IN_push;
    logic [WIDTH-1:0]    IN_pushData;
    logic                IN_pop;
    logic                IN_clear;
    logic                IN_recover;
    logic [c_ckpt_w-1:0] IN_recoverCkpt;
    logic                OUT_valid;
    logic [WIDTH-1:0]    OUT_data;
    logic [c_ckpt_w-1:0] OUT_ckpt;
    logic                OUT_underflow;

    modport master (
        output IN_push, IN_pushData, IN_pop, IN_clear, IN_recover, IN_recoverCkpt,
        input  OUT_valid, OUT_data, OUT_ckpt, OUT_underflow
    );

    modport slave (
        input  IN_push, IN_pushData, IN_pop, IN_clear, IN_recover, IN_recoverCkpt,
        output OUT_valid, OUT_data, OUT_ckpt, OUT_underflow
    );
endinterface
`default_nettype wire

// File: rtl/return_stack_spec.sv
`default_nettype none
// ============================================================================
// Module   : return_stack_spec
// Brief    : Return-address stack with replace-top, wrap-on-overflow, clear
//            and checkpoint/recover for mispredict repair.
// Revision : 1.0
// ============================================================================
module return_stack_spec #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 31
) (
    input  wire logic          clk,
    input  wire logic          rst,
    return_stack_spec_if.slave bus
);
    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_cnt_w  = $clog2(DEPTH) + 1;

    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_stack_q [DEPTH];
    logic [c_ptr_w-1:0] r_ptr_q;
    logic [c_ptr_w-1:0] w_ptr_d;
    logic [c_cnt_w-1:0] r_cnt_q;
    logic [c_cnt_w-1:0] w_cnt_d;

    logic               w_wr_en;
    logic [c_ptr_w-1:0] w_wr_idx;
    logic [WIDTH-1:0]   w_wr_data;

    logic [c_ptr_w-1:0] w_top_idx;
    logic               w_empty;
    logic [c_ptr_w-1:0] w_rec_ptr;
    logic [c_cnt_w-1:0] w_rec_cnt;
    logic [WIDTH-1:0]   w_rec_data;

    assign {w_rec_ptr, w_rec_cnt, w_rec_data} = bus.IN_recoverCkpt;

    assign w_top_idx = r_ptr_q - c_ptr_one;
    assign w_empty   = (r_cnt_q == c_cnt_zero);

    always_comb begin
        w_ptr_d   = r_ptr_q;
        w_cnt_d   = r_cnt_q;
        w_wr_en   = 1'b0;
        w_wr_idx  = r_ptr_q;
        w_wr_data = bus.IN_pushData;

        if (bus.IN_recover) begin
            w_ptr_d = w_rec_ptr;
            w_cnt_d = w_rec_cnt;
            // Re-write the checkpointed top in case a wrong-path push clobbered it.
            if (w_rec_cnt != c_cnt_zero) begin
                w_wr_en   = 1'b1;
                w_wr_idx  = w_rec_ptr - c_ptr_one;
                w_wr_data = w_rec_data;
            end
        end else if (bus.IN_clear) begin
            w_ptr_d = '0;
            w_cnt_d = '0;
        end else if (bus.IN_push && bus.IN_pop && !w_empty) begin
            w_wr_en  = 1'b1;
            w_wr_idx = w_top_idx;
        end else if (bus.IN_push) begin
            // When full, the slot at ptr holds the oldest entry, which is overwritten.
            w_wr_en = 1'b1;
            w_ptr_d = r_ptr_q + c_ptr_one;
            if (r_cnt_q != c_cnt_full) begin
                w_cnt_d = r_cnt_q + c_cnt_one;
            end
        end else if (bus.IN_pop && !w_empty) begin
            w_ptr_d = r_ptr_q - c_ptr_one;
            w_cnt_d = r_cnt_q - c_cnt_one;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr_q <= '0;
            r_cnt_q <= '0;
        end else begin
            r_ptr_q <= w_ptr_d;
            r_cnt_q <= w_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_stack_q[w_wr_idx] <= w_wr_data;
        end
    end

    assign bus.OUT_valid     = !w_empty;
    assign bus.OUT_data      = r_stack_q[w_top_idx];
    assign bus.OUT_ckpt      = {r_ptr_q, r_cnt_q, r_stack_q[w_top_idx]};
    assign bus.OUT_underflow = bus.IN_pop & ~bus.IN_push & w_empty
                             & ~bus.IN_recover & ~bus.IN_clear;
endmodule
`default_nettype wire

// File: tb/tb_return_stack_spec.sv
`default_nettype none
// ============================================================================
// Module   : tb_return_stack_spec
// Brief    : Directed scenarios plus random traffic against a slot-array model.
// Revision : 1.0
// ============================================================================
module tb_return_stack_spec;
    localparam int D  = 4;
    localparam int W  = 31;
    localparam int PW = $clog2(D);
    localparam int CW = PW + 1;
    localparam int KW = PW + CW + W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    return_stack_spec_if #(.DEPTH(D), .WIDTH(W)) bus ();
    return_stack_spec #(.DEPTH(D), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: slots addressed by absolute position, plus which ones hold known data.
    logic [W-1:0]  m_mem [D];
    bit            m_known [D];
    int            m_ptr;
    int            m_cnt;
    logic [KW-1:0] saved [4];
    logic [KW-1:0] ck_a, ck_b;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_top();
        return (m_ptr + D - 1) % D;
    endfunction

    function automatic logic [KW-1:0] m_ckpt();
        logic [W-1:0] d;
        d = m_known[m_top()] ? m_mem[m_top()] : '0;
        return {PW'(m_ptr), CW'(m_cnt), d};
    endfunction

    task automatic m_write(int idx, logic [W-1:0] d);
        m_mem[idx]   = d;
        m_known[idx] = 1'b1;
    endtask

    task automatic model_update(bit push, logic [W-1:0] data, bit pop, bit clr, bit rec,
                                logic [KW-1:0] ck);
        int p, c;
        p = int'(ck[KW-1 -: PW]);
        c = int'(ck[W+CW-1 -: CW]);
        if (rec) begin
            m_ptr = p;
            m_cnt = c;
            if (c != 0) m_write((p + D - 1) % D, ck[W-1:0]);
        end else if (clr) begin
            m_ptr = 0;
            m_cnt = 0;
        end else if (push && pop && m_cnt != 0) begin
            m_write(m_top(), data);
        end else if (push) begin
            m_write(m_ptr, data);
            m_ptr = (m_ptr + 1) % D;
            if (m_cnt < D) m_cnt++;
        end else if (pop && m_cnt != 0) begin
            m_ptr = (m_ptr + D - 1) % D;
            m_cnt--;
        end
    endtask

    task automatic check_state(string tag);
        logic [PW+CW-1:0] exp_pc;
        exp_pc = {PW'(m_ptr), CW'(m_cnt)};
        check({tag, "_valid"}, bus.OUT_valid, m_cnt != 0);
        check({tag, "_ptrcnt"}, bus.OUT_ckpt[KW-1:W], exp_pc);
        if (m_cnt != 0 && m_known[m_top()]) begin
            check({tag, "_data"}, bus.OUT_data, m_mem[m_top()]);
            check({tag, "_ckpt"}, bus.OUT_ckpt, m_ckpt());
        end
    endtask

    task automatic drive_idle();
        bus.IN_push        = 1'b0;
        bus.IN_pushData    = '0;
        bus.IN_pop         = 1'b0;
        bus.IN_clear       = 1'b0;
        bus.IN_recover     = 1'b0;
        bus.IN_recoverCkpt = '0;
    endtask

    // One clock cycle of requests; entered and left at a falling edge.
    task automatic step(string tag, bit push, logic [W-1:0] data, bit pop, bit clr, bit rec,
                        logic [KW-1:0] ck);
        bit exp_uf;
        bus.IN_push        = push;
        bus.IN_pushData    = data;
        bus.IN_pop         = pop;
        bus.IN_clear       = clr;
        bus.IN_recover     = rec;
        bus.IN_recoverCkpt = ck;
        exp_uf = pop && !push && m_cnt == 0 && !rec && !clr;
        #1;
        check({tag, "_uf"}, bus.OUT_underflow, exp_uf);
        @(posedge clk);
        model_update(push, data, pop, clr, rec, ck);
        @(negedge clk);
        drive_idle();
        check_state(tag);
    endtask

    task automatic push1(string tag, logic [W-1:0] d);
        step(tag, 1'b1, d, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic pop1(string tag);
        step(tag, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    endtask

    task automatic clear1(string tag);
        step(tag, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    endtask

    initial begin
        for (int i = 0; i < D; i++) m_known[i] = 1'b0;
        m_ptr = 0;
        m_cnt = 0;
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_valid", bus.OUT_valid, 1'b0);
        check("reset_ptrcnt", bus.OUT_ckpt[KW-1:W], '0);
        check("reset_uf", bus.OUT_underflow, 1'b0);
        rst = 1'b0;

        // Basic LIFO order.
        push1("t1_p1", 31'h100);
        push1("t1_p2", 31'h200);
        push1("t1_p3", 31'h300);
        check("t1_top", bus.OUT_data, 31'h300);
        check("t1_cnt", bus.OUT_ckpt[W+CW-1 -: CW], 3);
        pop1("t1_q1");
        check("t1_pop1", bus.OUT_data, 31'h200);
        pop1("t1_q2");
        check("t1_pop2", bus.OUT_data, 31'h100);
        pop1("t1_q3");
        check("t1_empty", bus.OUT_valid, 1'b0);

        // Underflow and push+pop on an empty stack.
        bus.IN_pop = 1'b1;
        #1;
        check("t2_uf_const", bus.OUT_underflow, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        check_state("t2_pop_empty");
        step("t2_pp", 1'b1, 31'h40, 1'b1, 1'b0, 1'b0, '0);
        check("t2_pp_data", bus.OUT_data, 31'h40);
        check("t2_pp_cnt", bus.OUT_ckpt[W+CW-1 -: CW], 1);
        clear1("t2_clr");

        // Overflow wraps and keeps the newest DEPTH entries.
        for (int i = 1; i <= 6; i++) push1("t3_push", W'(i));
        check("t3_ptrcnt", bus.OUT_ckpt[KW-1:W], {2'd2, 3'd4});
        for (int i = 6; i >= 3; i--) begin
            check("t3_popval", bus.OUT_data, W'(i));
            pop1("t3_pop");
        end
        check("t3_empty", bus.OUT_valid, 1'b0);

        // Replace-top.
        clear1("t4_clr");
        push1("t4_a", 31'hA);
        push1("t4_b", 31'hB);
        step("t4_pp", 1'b1, 31'hC, 1'b1, 1'b0, 1'b0, '0);
        check("t4_top", bus.OUT_data, 31'hC);
        check("t4_cnt", bus.OUT_ckpt[W+CW-1 -: CW], 2);
        pop1("t4_pop");
        check("t4_after", bus.OUT_data, 31'hA);

        // Checkpoint then wrong-path pop/push repaired by recover.
        clear1("t5_clr");
        push1("t5_a", 31'hA);
        push1("t5_b", 31'hB);
        ck_a = m_ckpt();
        pop1("t5_pop");
        push1("t5_e", 31'hE);
        check("t5_wrong", bus.OUT_data, 31'hE);
        step("t5_rec", 1'b0, '0, 1'b0, 1'b0, 1'b1, ck_a);
        check("t5_rec_top", bus.OUT_data, 31'hB);
        check("t5_rec_cnt", bus.OUT_ckpt[W+CW-1 -: CW], 2);
        pop1("t5_pop2");
        check("t5_after", bus.OUT_data, 31'hA);

        // Recover beats clear and push; the dropped push must not reach storage.
        clear1("t6_clr");
        push1("t6_1", 31'h11);
        push1("t6_2", 31'h22);
        push1("t6_3", 31'h33);
        push1("t6_4", 31'h44);
        ck_a = m_ckpt();
        pop1("t6_q1");
        pop1("t6_q2");
        ck_b = m_ckpt();
        step("t6_prio", 1'b1, 31'h77, 1'b0, 1'b1, 1'b1, ck_b);
        check("t6_prio_top", bus.OUT_data, 31'h22);
        check("t6_prio_cnt", bus.OUT_ckpt[W+CW-1 -: CW], 2);
        step("t6_rec_a", 1'b0, '0, 1'b0, 1'b0, 1'b1, ck_a);
        pop1("t6_q3");
        check("t6_slot_kept", bus.OUT_data, 31'h33);

        // Asynchronous reset between edges.
        push1("t6_5", 31'h55);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_valid", bus.OUT_valid, 1'b0);
        check("t6_async_ptrcnt", bus.OUT_ckpt[KW-1:W], '0);
        m_ptr = 0;
        m_cnt = 0;
        @(negedge clk);
        rst = 1'b0;

        // Random traffic with occasional clear/recover from earlier checkpoints.
        for (int i = 0; i < 4; i++) saved[i] = m_ckpt();
        for (int n = 0; n < 1500; n++) begin
            bit p, q, c, r;
            p = ($urandom % 2) == 1;
            q = ($urandom % 100) < 45;
            c = ($urandom % 100) < 4;
            r = ($urandom % 100) < 6;
            if (($urandom % 4) == 0) saved[$urandom % 4] = m_ckpt();
            step("rnd", p, W'($urandom), q, c, r, saved[$urandom % 4]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
